// File: rtl/fusion_pkg.sv
// fusion_pkg
//   Shared definitions between the fusion MAC unit and its drain stage:
//   precision-mode encodings, per-mode lane widths and lane counts, and the
//   drain FSM state encoding.
//   No ports (package).
package fusion_pkg;

  // Precision-mode encodings, shared with the fusion MAC unit.
  localparam logic [1:0] MODE_2B      = 2'b00;
  localparam logic [1:0] MODE_4B      = 2'b01;
  localparam logic [1:0] MODE_8B      = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Width of one accumulator lane in each mode.
  localparam int LANE_W_2B = 8;
  localparam int LANE_W_4B = 12;
  localparam int LANE_W_8B = 20;

  // Number of lanes packed into the accumulator in each mode.
  localparam int LANE_CNT_2B = 16;
  localparam int LANE_CNT_4B = 4;
  localparam int LANE_CNT_8B = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drainState_e;

  // Number of lanes to stream for a given latched mode. The illegal mode is
  // never latched, so it simply falls into the 2b branch.
  function automatic logic [4:0] laneCount(input logic [1:0] mode);
    case (mode)
      MODE_8B: laneCount = 5'(LANE_CNT_8B);
      MODE_4B: laneCount = 5'(LANE_CNT_4B);
      default: laneCount = 5'(LANE_CNT_2B);
    endcase
  endfunction

endpackage

// File: rtl/fusion_requant.sv
// fusion_requant
//   Combinational requantiser: arithmetic right shift of a sign-extended lane
//   followed by saturation to OUT_W bits, either signed or unsigned.
//   Ports:
//     raw_i        in  RAW_W    sign-extended raw lane value
//     shift_i      in  SHIFT_W  arithmetic right-shift amount
//     satSigned_i  in  1        1: clamp to signed OUT_W range, 0: unsigned range
//     data_o       out OUT_W    requantised value
module fusion_requant #(
  parameter int RAW_W   = 20,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic signed [RAW_W-1:0]   raw_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      satSigned_i,
  output logic        [OUT_W-1:0]   data_o
);

  localparam logic signed [RAW_W-1:0] S_MAX = RAW_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RAW_W-1:0] S_MIN = RAW_W'(-(1 << (OUT_W - 1)));
  localparam logic signed [RAW_W-1:0] U_MAX = RAW_W'((1 << OUT_W) - 1);

  logic signed [RAW_W-1:0] shifted;
  logic signed [RAW_W-1:0] clamped;

  // Kept as if/else rather than a ternary so the shift stays signed
  // (arithmetic); oversized shifts collapse to pure sign fill.
  always_comb begin
    if (32'(shift_i) >= RAW_W) begin
      shifted = {RAW_W{raw_i[RAW_W-1]}};
    end else begin
      shifted = raw_i >>> shift_i;
    end
  end

  always_comb begin
    clamped = shifted;
    if (satSigned_i) begin
      if (shifted > S_MAX) begin
        clamped = S_MAX;
      end else if (shifted < S_MIN) begin
        clamped = S_MIN;
      end
    end else begin
      if (shifted[RAW_W-1]) begin
        clamped = '0;
      end else if (shifted > U_MAX) begin
        clamped = U_MAX;
      end
    end
  end

  assign data_o = OUT_W'(clamped);

endmodule

// File: rtl/fusion_drain.sv
// fusion_drain
//   Snapshots the fusion unit's packed accumulator on a tile-done strobe and
//   streams its lanes (1x20b, 4x12b or 16x8b) one per valid/ready handshake,
//   each requantised to OUT_W bits.
//   Ports:
//     clk, nrst    clock, synchronous active-low reset
//     sum_in       packed 128-bit accumulator
//     mode_in      precision mode (00=2b, 01=4b, 10=8b, 11=illegal)
//     tile_done    one-cycle strobe, sum_in is final this cycle
//     shift        right-shift amount, sampled with tile_done
//     sat_signed   saturation mode, sampled with tile_done
//     out_valid    lane data valid
//     out_ready    consumer ready
//     out_data     requantised lane value
//     out_raw      unshifted lane, sign-extended to RAW_W
//     out_lane     lane index
//     out_last     final lane of the tile
//     busy         drain in progress
//     drop_err     sticky error (strobe dropped or illegal mode)
//     clear_err    clears drop_err
module fusion_drain #(
  parameter int OUT_W   = 8,
  parameter int RAW_W   = 20,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [127:0]       sum_in,
  input  logic [1:0]         mode_in,
  input  logic               tile_done,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sat_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [RAW_W-1:0]   out_raw,
  output logic [3:0]         out_lane,
  output logic               out_last,
  output logic               busy,
  output logic               drop_err,
  input  logic               clear_err
);

  import fusion_pkg::*;

  drainState_e        state_q, state_d;
  logic [127:0]       snapSum_q;
  logic [1:0]         snapMode_q;
  logic [SHIFT_W-1:0] snapShift_q;
  logic               snapSat_q;
  logic [3:0]         laneCnt_q, laneCnt_d;
  logic               dropErr_q, dropErr_d;

  logic                    transfer;
  logic                    lastLane;
  logic                    finalXfer;
  logic                    accept;
  logic                    dropEvent;
  logic [7:0]              shAmt;
  logic [LANE_W_8B-1:0]    laneBits;
  logic signed [RAW_W-1:0] rawLane;
  logic [OUT_W-1:0]        reqData;

  assign lastLane  = ({1'b0, laneCnt_q} == (laneCount(snapMode_q) - 5'd1));
  assign transfer  = out_valid && out_ready;
  assign finalXfer = transfer && lastLane;
  // A new tile is taken when idle, or back-to-back on the final transfer so
  // the stream has no bubble between tiles.
  assign accept    = tile_done && (mode_in != MODE_ILLEGAL) &&
                     ((state_q == IDLE) || finalXfer);
  assign dropEvent = tile_done && !accept;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRAIN;
      DRAIN:   if (finalXfer && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == DRAIN);
    busy      = (state_q == DRAIN);
  end

  always_comb begin
    laneCnt_d = laneCnt_q;
    if (accept) begin
      laneCnt_d = '0;
    end else if (transfer) begin
      laneCnt_d = lastLane ? 4'd0 : laneCnt_q + 4'd1;
    end
  end

  // Set has priority over clear so a coincident error is never lost.
  always_comb begin
    dropErr_d = dropErr_q;
    if (dropEvent) begin
      dropErr_d = 1'b1;
    end else if (clear_err) begin
      dropErr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      snapSum_q   <= '0;
      snapMode_q  <= MODE_2B;
      snapShift_q <= '0;
      snapSat_q   <= 1'b0;
      laneCnt_q   <= '0;
      dropErr_q   <= 1'b0;
    end else begin
      if (accept) begin
        snapSum_q   <= sum_in;
        snapMode_q  <= mode_in;
        snapShift_q <= shift;
        snapSat_q   <= sat_signed;
      end
      laneCnt_q <= laneCnt_d;
      dropErr_q <= dropErr_d;
    end
  end

  // Lane extraction: shift the snapshot so the active lane sits at bit 0,
  // then sign-extend the lane-width slice.
  always_comb begin
    case (snapMode_q)
      MODE_8B: shAmt = 8'd0;
      MODE_4B: shAmt = 8'(laneCnt_q) * 8'(LANE_W_4B);
      default: shAmt = 8'(laneCnt_q) * 8'(LANE_W_2B);
    endcase
    laneBits = LANE_W_8B'(snapSum_q >> shAmt);
    case (snapMode_q)
      MODE_8B: rawLane = RAW_W'($signed(laneBits[LANE_W_8B-1:0]));
      MODE_4B: rawLane = RAW_W'($signed(laneBits[LANE_W_4B-1:0]));
      default: rawLane = RAW_W'($signed(laneBits[LANE_W_2B-1:0]));
    endcase
  end

  fusion_requant #(
    .RAW_W   (RAW_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .raw_i       (rawLane),
    .shift_i     (snapShift_q),
    .satSigned_i (snapSat_q),
    .data_o      (reqData)
  );

  assign out_data = reqData;
  assign out_raw  = rawLane;
  assign out_lane = laneCnt_q;
  assign out_last = lastLane;
  assign drop_err = dropErr_q;

endmodule

// File: tb/tb_fusion_drain.sv
// tb_fusion_drain
//   Self-checking bench for fusion_drain: directed scenarios followed by
//   randomized traffic, compared every cycle against a queue-based model of
//   the expected output beats.
module tb_fusion_drain;

  logic         clk;
  logic         nrst;
  logic [127:0] sumIn;
  logic [1:0]   modeIn;
  logic         tileDone;
  logic [4:0]   shiftAmt;
  logic         satSigned;
  logic         outValid;
  logic         outReady;
  logic [7:0]   outData;
  logic [19:0]  outRaw;
  logic [3:0]   outLane;
  logic         outLast;
  logic         busy;
  logic         dropErr;
  logic         clearErr;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    logic [7:0]  data;
    logic [19:0] raw;
    logic [3:0]  lane;
    bit          last;
  } beat_t;

  beat_t expQ[$];
  bit    expErr = 0;

  fusion_drain #(
    .OUT_W   (8),
    .RAW_W   (20),
    .SHIFT_W (5)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .sum_in     (sumIn),
    .mode_in    (modeIn),
    .tile_done  (tileDone),
    .shift      (shiftAmt),
    .sat_signed (satSigned),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_raw    (outRaw),
    .out_lane   (outLane),
    .out_last   (outLast),
    .busy       (busy),
    .drop_err   (dropErr),
    .clear_err  (clearErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] randSum();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input bit rstN, input bit tile, input logic [1:0] m,
                               input logic [127:0] s, input logic [4:0] sh,
                               input bit sat, input bit rdy, input bit clr);
    nrst      = rstN;
    tileDone  = tile;
    modeIn    = m;
    sumIn     = s;
    shiftAmt  = sh;
    satSigned = sat;
    outReady  = rdy;
    clearErr  = clr;
  endtask

  // No strobe; mode/sum/shift carry junk that must be ignored.
  task automatic quiet(input bit rdy);
    applyStimulus(1'b1, 1'b0, 2'($urandom_range(0, 3)), randSum(),
                  5'($urandom_range(0, 31)), 1'($urandom), rdy, 1'b0);
  endtask

  // Expected beats of one tile, from plain signed arithmetic on each lane.
  task automatic buildBeats(input logic [1:0] m, input logic [127:0] s, input int sh, input bit sat);
    int     n, w;
    longint v, q;
    beat_t  b;
    n = (m == 2'b10) ? 1 : (m == 2'b01) ? 4 : 16;
    w = (m == 2'b10) ? 20 : (m == 2'b01) ? 12 : 8;
    for (int i = 0; i < n; i++) begin
      v = longint'(64'((s >> (w * i)) & ((128'd1 << w) - 128'd1)));
      if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      q = v >>> sh;
      if (sat) begin
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
      end else begin
        if (q < 0) q = 0;
        else if (q > 255) q = 255;
      end
      b.raw  = 20'(v);
      b.data = 8'(q);
      b.lane = 4'(i);
      b.last = (i == n - 1);
      expQ.push_back(b);
    end
  endtask

  task automatic modelStep();
    bit accept;
    if (!nrst) begin
      expQ.delete();
      expErr = 0;
      return;
    end
    if (expQ.size() != 0 && outReady) void'(expQ.pop_front());
    accept = tileDone && (modeIn != 2'b11) && (expQ.size() == 0);
    if (tileDone && !accept) expErr = 1;
    else if (clearErr) expErr = 0;
    if (accept) buildBeats(modeIn, sumIn, int'(shiftAmt), satSigned);
  endtask

  task automatic compareAll(input bit wasReset);
    checkOutput("out_valid", 32'(outValid), 32'(expQ.size() != 0));
    checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
    checkOutput("drop_err", 32'(dropErr), 32'(expErr));
    if (expQ.size() != 0) begin
      checkOutput("out_data", 32'(outData), 32'(expQ[0].data));
      checkOutput("out_raw", 32'(outRaw), 32'(expQ[0].raw));
      checkOutput("out_lane", 32'(outLane), 32'(expQ[0].lane));
      checkOutput("out_last", 32'(outLast), 32'(expQ[0].last));
    end
    if (wasReset) begin
      checkOutput("rst_data", 32'(outData), 32'd0);
      checkOutput("rst_raw", 32'(outRaw), 32'd0);
      checkOutput("rst_lane", 32'(outLane), 32'd0);
      checkOutput("rst_last", 32'(outLast), 32'd0);
    end
  endtask

  task automatic stepCycle();
    bit wasReset;
    @(posedge clk);
    wasReset = !nrst;
    modelStep();
    @(negedge clk);
    compareAll(wasReset);
  endtask

  initial begin
    logic [127:0] s;

    applyStimulus(1'b0, 1'b0, 2'b00, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();

    $display("[TB] 8b tile, signed then unsigned saturation");
    s = randSum();
    s[19:0] = 20'h003E8;
    applyStimulus(1'b1, 1'b1, 2'b10, s, 5'd2, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (2) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b1, 1'b1, 2'b10, s, 5'd2, 1'b0, 1'b1, 1'b0);
    stepCycle();
    repeat (2) begin quiet(1'b1); stepCycle(); end

    $display("[TB] 4b tile, boundary lanes");
    s = randSum();
    s[47:0] = {12'h800, 12'h7FF, 12'h064, 12'hFF6};
    applyStimulus(1'b1, 1'b1, 2'b01, s, 5'd0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (6) begin quiet(1'b1); stepCycle(); end

    $display("[TB] 2b tile, unsigned, ready toggling");
    s = '0;
    for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(i - 8);
    applyStimulus(1'b1, 1'b1, 2'b00, s, 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int c = 0; c < 36; c++) begin quiet(1'(c + 1)); stepCycle(); end

    $display("[TB] strobe dropped mid-drain, then cleared");
    applyStimulus(1'b1, 1'b1, 2'b01, randSum(), 5'd3, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (2) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b1, 1'b1, 2'b01, randSum(), 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    repeat (4) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b1, 1'b0, 2'b00, randSum(), 5'd0, 1'b0, 1'b1, 1'b1);
    stepCycle();

    $display("[TB] illegal mode strobe in idle");
    applyStimulus(1'b1, 1'b1, 2'b11, randSum(), 5'd0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (2) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b1, 1'b0, 2'b00, randSum(), 5'd0, 1'b0, 1'b1, 1'b1);
    stepCycle();

    $display("[TB] back-to-back tiles on final transfer");
    applyStimulus(1'b1, 1'b1, 2'b01, randSum(), 5'd1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (3) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b1, 1'b1, 2'b01, randSum(), 5'd2, 1'b0, 1'b1, 1'b0);
    stepCycle();
    repeat (6) begin quiet(1'b1); stepCycle(); end

    $display("[TB] reset in the middle of a 2b tile");
    applyStimulus(1'b1, 1'b1, 2'b00, randSum(), 5'd1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (5) begin quiet(1'b1); stepCycle(); end
    applyStimulus(1'b0, 1'b0, 2'b00, randSum(), 5'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    quiet(1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 2'b00, randSum(), 5'd0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    repeat (24) begin quiet(1'($urandom)); stepCycle(); end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(1'($urandom_range(0, 299) != 0),
                    1'($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)),
                    randSum(),
                    ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6)),
                    1'($urandom),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0));
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fusion_drain.md
Name: fusion_drain

Overview:
- Downstream consumer of the fusion MAC unit's packed 128-bit accumulator `sum`.
- On a tile-done strobe it snapshots `sum` and the precision mode, then unpacks the per-mode lanes: 1×20b, 4×12b or 16×8b.
- Each lane is requantised to 8 bits by arithmetic right shift plus saturation.
- Lanes are streamed out one per handshake over valid/ready, toward the output buffer/writeback stage.

Parameters:
- OUT_W, 8, requantised output width (signed or unsigned).
- RAW_W, 20, width of the sign-extended raw lane output (widest lane, 8b×8b mode).
- SHIFT_W, 5, width of the shift-amount input.

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- sum_in  in  128  packed accumulator from the fusion unit
- mode_in  in  2  precision mode: 00=2bx2b, 01=4bx4b, 10=8bx8b, 11=illegal
- tile_done  in  1  one-cycle strobe; sum_in holds the final tile result this cycle
- shift  in  SHIFT_W  arithmetic right-shift amount, sampled at tile_done
- sat_signed  in  1  1: clamp to [-128,127]; 0: clamp to [0,255]; sampled at tile_done
- out_valid  out  1  lane data valid
- out_ready  in  1  consumer ready
- out_data  out  OUT_W  requantised lane value
- out_raw  out  RAW_W  unshifted lane value, sign-extended to RAW_W
- out_lane  out  4  lane index, 0-based
- out_last  out  1  high on the final lane of a tile
- busy  out  1  drain in progress (state DRAIN)
- drop_err  out  1  sticky error flag
- clear_err  in  1  clears drop_err

Behaviour:
- Reset: on clk edge with nrst=0:
  - state=IDLE; out_valid=0, busy=0, drop_err=0, out_lane=0, out_last=0.
  - Snapshot registers cleared, so out_data=0 and out_raw=0.
  - Reset mid-drain aborts the tile silently; no output after reset until the next tile_done.
- States:
  - IDLE: waiting for a tile.
  - DRAIN: out_valid=1, busy=1.
- IDLE→DRAIN: tile_done=1 and mode_in≠11 at an edge.
  - Latches sum_in, mode_in, shift and sat_signed; lane counter=0.
  - out_valid rises the following cycle, i.e. 1-cycle latency from strobe to first valid.
- Lane count: mode 10 → 1; mode 01 → 4; mode 00 → 16.
- Lane i extraction:
  - mode 10: snap[19:0].
  - mode 01: snap[12i+11:12i].
  - mode 00: snap[8i+7:8i].
  - Bits outside the active lanes are ignored.
- Arithmetic:
  - Lanes are two's complement; sign-extend to RAW_W → out_raw.
  - Arithmetic right shift by shift; shift≥RAW_W yields all sign bits.
  - Saturate per sat_signed: signed mode clamps to [-128,127]; unsigned mode clamps negatives to 0 and values >255 to 255.
  - out_data, out_raw, out_lane and out_last are combinational from registered snapshot/counter only; they are stable while out_valid=1 and out_ready=0.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both high.
  - On transfer the counter increments.
  - out_last = (counter == lane_count-1).
  - Transfer with out_last → IDLE.
- Simultaneous events:
  - tile_done on the same edge as the final transfer is accepted: new snapshot, stay in DRAIN, no bubble, no error.
  - tile_done in DRAIN otherwise: strobe ignored, snapshot untouched, drop_err←1.
  - tile_done with mode_in=11: ignored, drop_err←1.
- Error clearing:
  - clear_err=1 clears drop_err.
  - If clear_err and a new error coincide, the set wins.
- Mode change: mode_in changes during DRAIN have no effect; the latched mode is used.

Decomposition:
- Shared package (fusion_pkg):
  - Mode localparams MODE_2B=2'b00, MODE_4B=2'b01, MODE_8B=2'b10, shared with the fusion unit.
  - Lane widths 8/12/20 and lane counts 16/4/1.
  - State encoding.
- One sub-module: fusion_requant.
  - Combinational: sign-extended raw lane, shift, sat_signed → out_data.
  - Reusable by a future per-lane parallel drain.

Test Plan:
- 8b mode, sum_in[19:0]=0x003E8 (1000), shift=2, sat_signed=1 → one beat:
  - out_raw=1000, out_data=0x7F, out_last=1, out_lane=0.
  - Repeat with sat_signed=0 → out_data=0xFA.
- 4b mode, lanes {0xFF6, 0x064, 0x7FF, 0x800}, shift=0, signed, out_ready=1 → 4 consecutive beats:
  - out_data 0xF6, 0x64, 0x7F, 0x80.
  - out_last only on lane 3; busy drops the cycle after.
- 2b mode, lane i=i-8 (0xF8…0x07), unsigned, out_ready toggling 1010… → 16 beats, lane 0..15 in order:
  - outputs 0x00 for lanes 0–8, 0x01…0x07 for lanes 9–15.
  - Data held stable on stalls.
- tile_done while on lane 2 of a 4b tile → drop_err=1, remaining lanes keep original data.
  - clear_err pulse → drop_err=0.
  - tile_done with mode_in=11 in IDLE → no out_valid, drop_err=1.
- tile_done coincident with final transfer of a 4b tile → next tile's lane 0 valid next cycle, no gap, drop_err stays 0.
- nrst=0 during lane 5 of a 2b tile → next cycle out_valid=0, busy=0, out_lane=0.
  - Subsequent tile_done drains normally.
